// File: rtl/uart_cmd_decoder.sv
// Command decoder behind uart_rx: parses 3A/CMD/DATA/CSUM packets, updates an LED register
// and answers every finished packet with ACK (0x06) or NAK (0x15) through uart_tx.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 104160,
  parameter bit          ACK_EN         = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rd_data,
  input  logic       rd_valid,
  input  logic       frame_err,
  input  logic       parity_err,
  output logic       read_en,
  output logic [7:0] tr_data,
  output logic       send_en,
  input  logic       done,
  output logic [7:0] led,
  output logic [7:0] err_cnt,
  output logic       pkt_ok,
  output logic       busy
);

  localparam logic [7:0]      Sof     = 8'h3A;
  localparam logic [7:0]      Ack     = 8'h06;
  localparam logic [7:0]      Nak     = 8'h15;
  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StHunt, StCmd, StData, StCsum, StExec, StAckWait} state_e;

  state_e          state_q, state_d;
  logic            pop_q;
  logic [7:0]      cmd_q, cmd_d, data_q, data_d, csum_q, csum_d;
  logic [7:0]      led_q, led_d, err_q, err_d, tr_q, tr_d;
  logic            send_q, send_d, pkt_ok_q, pkt_ok_d, busy_q, busy_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic       pop, byte_err, in_pkt, tmo_fire, cmd_known, err_inc, resp_req;
  logic [7:0] led_new, resp_byte;

  // Pop only every other cycle: the FIFO head needs one cycle to advance.
  assign pop      = !reset && rd_valid && !pop_q &&
                    (state_q inside {StHunt, StCmd, StData, StCsum});
  assign byte_err = frame_err | parity_err;
  assign in_pkt   = state_q inside {StCmd, StData, StCsum};
  assign tmo_fire = in_pkt && !pop && (tmo_q == TmoLast);

  always_comb begin
    cmd_known = 1'b1;
    led_new   = led_q;
    case (cmd_q)
      8'h41:   led_new = data_q;
      8'h42:   led_new = led_q | data_q;
      8'h43:   led_new = led_q & ~data_q;
      8'h44:   led_new = led_q ^ data_q;
      default: cmd_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    csum_d    = csum_q;
    led_d     = led_q;
    tr_d      = tr_q;
    send_d    = 1'b0;
    pkt_ok_d  = 1'b0;
    err_inc   = 1'b0;
    resp_req  = 1'b0;
    resp_byte = Nak;
    tmo_d     = (pop || !in_pkt) ? '0 : tmo_q + TmoW'(1);

    unique case (state_q)
      StHunt: begin
        if (pop) begin
          if (byte_err) begin
            err_inc = 1'b1;
          end else if (rd_data == Sof) begin
            state_d = StCmd;
          end
        end
      end
      StCmd, StData, StCsum: begin
        if (pop && byte_err) begin
          err_inc  = 1'b1;
          resp_req = 1'b1;
        end else if (pop) begin
          if (state_q == StCmd) begin
            cmd_d   = rd_data;
            state_d = StData;
          end else if (state_q == StData) begin
            data_d  = rd_data;
            state_d = StCsum;
          end else begin
            csum_d  = rd_data;
            state_d = StExec;
          end
        end else if (tmo_fire) begin
          err_inc = 1'b1;
          state_d = StHunt;
        end
      end
      StExec: begin
        resp_req = 1'b1;
        if ((csum_q == (cmd_q ^ data_q)) && cmd_known) begin
          led_d     = led_new;
          pkt_ok_d  = 1'b1;
          resp_byte = Ack;
        end else begin
          err_inc = 1'b1;
        end
      end
      StAckWait: begin
        // A done coinciding with our own send_en belongs to an older frame.
        if (done && !send_q) state_d = StHunt;
      end
      default: state_d = StHunt;
    endcase

    if (resp_req) begin
      if (ACK_EN) begin
        state_d = StAckWait;
        send_d  = 1'b1;
        tr_d    = resp_byte;
      end else begin
        state_d = StHunt;
      end
    end

    err_d  = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    busy_d = (state_d != StHunt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StHunt;
      pop_q    <= 1'b0;
      cmd_q    <= 8'h00;
      data_q   <= 8'h00;
      csum_q   <= 8'h00;
      led_q    <= 8'h00;
      err_q    <= 8'h00;
      tr_q     <= 8'h00;
      send_q   <= 1'b0;
      pkt_ok_q <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pop_q    <= pop;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      csum_q   <= csum_d;
      led_q    <= led_d;
      err_q    <= err_d;
      tr_q     <= tr_d;
      send_q   <= send_d;
      pkt_ok_q <= pkt_ok_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
    end
  end

  assign read_en = pop;
  assign tr_data = tr_q;
  assign send_en = send_q;
  assign led     = led_q;
  assign err_cnt = err_q;
  assign pkt_ok  = pkt_ok_q;
  assign busy    = busy_q;

endmodule
